// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INST_WIDTH         = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
    localparam int unsigned DEFAULT_RESET_PC   = 0;

    // Instruction forced onto the decode bus whenever no valid instruction is present.
    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry skid buffer holding an instruction and its PC while decode stalls.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  unload,
    input  logic [INST_WIDTH-1:0] load_inst,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    output logic                  valid,
    output logic [INST_WIDTH-1:0] buf_inst,
    output logic [ADDR_WIDTH-1:0] buf_pc
);

    logic                  valid_q, valid_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;

    // Clear beats load, load beats unload.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            pc_d    = load_pc;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid    = valid_q;
    assign buf_inst = inst_q;
    assign buf_pc   = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem one word at a time, feeds decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [ADDR_WIDTH-1:0] inst_link,
    output logic                  inst_valid
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_q, req_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [ADDR_WIDTH-1:0] inst_link_q, inst_link_d;
    logic                  inst_valid_q, inst_valid_d;

    logic                  buf_clear, buf_load, buf_unload;
    logic                  buf_valid;
    logic [INST_WIDTH-1:0] buf_inst;
    logic [ADDR_WIDTH-1:0] buf_pc;
    logic [ADDR_WIDTH-1:0] req_next;

    assign req_next = req_addr_q + ADDR_WIDTH'(1);

    fetch_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (buf_clear),
        .load      (buf_load),
        .unload    (buf_unload),
        .load_inst (imem_rdata),
        .load_pc   (req_addr_q),
        .valid     (buf_valid),
        .buf_inst  (buf_inst),
        .buf_pc    (buf_pc)
    );

    // Next-state, PC, request and output-register logic; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_link_d  = inst_link_q;
        inst_valid_d = inst_valid_q;
        buf_clear    = 1'b0;
        buf_load     = 1'b0;
        buf_unload   = 1'b0;

        if (redirect) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            buf_clear    = 1'b1;
            pc_d         = redirect_pc;
            // A request still in flight must complete before the new target is issued.
            if ((state_q == ST_FETCH || state_q == ST_DRAIN) && !imem_ack) begin
                state_d = ST_DRAIN;
            end else begin
                req_addr_d = redirect_pc;
                state_d    = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_START: begin
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        pc_d = req_next;
                        if (!inst_valid_q || !stall) begin
                            inst_d       = imem_rdata;
                            inst_pc_d    = req_addr_q;
                            inst_link_d  = req_next;
                            inst_valid_d = 1'b1;
                            req_addr_d   = req_next;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = ST_FULL;
                        end
                    end else if (!stall) begin
                        inst_valid_d = 1'b0;
                        inst_d       = NOP_INST;
                    end
                end
                ST_FULL: begin
                    if (!stall) begin
                        inst_d       = buf_inst;
                        inst_pc_d    = buf_pc;
                        inst_link_d  = buf_pc + ADDR_WIDTH'(1);
                        inst_valid_d = buf_valid;
                        buf_unload   = 1'b1;
                        req_addr_d   = pc_q;
                        state_d      = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        req_addr_d = pc_q;
                        state_d    = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_START;
                end
            endcase
        end

        req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    end

    // State, PC, request and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_START;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            req_q        <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= '0;
            inst_link_q  <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            req_q        <= req_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_link_q  <= inst_link_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = req_addr_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_link  = inst_link_q;
    assign inst_valid = inst_valid_q;

endmodule
